alu_share_arb: RTL and testbench



---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_arb_pick.sv | 57 +++++
 rtl/alu_share_arb.sv | 140 ++++++++++++++
 tb/tb_alu_share_arb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: EXE_CMD encodings,
// NZCV bit positions, command classification and the arbiter state type.
package alu_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  // Status register layout is {N,Z,C,V}
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FAVOR1 = 1'b1
  } arb_state_t;

  // Arithmetic ops produce all four flags
  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_ADC) ||
           (cmd == CMD_SUB) || (cmd == CMD_SBC);
  endfunction

  // Logic/move ops only produce meaningful N and Z
  function automatic logic is_logic(input logic [3:0] cmd);
    return (cmd == CMD_MOV) || (cmd == CMD_MVN) || (cmd == CMD_AND) ||
           (cmd == CMD_ORR) || (cmd == CMD_EOR);
  endfunction

  function automatic logic is_supported(input logic [3:0] cmd);
    return is_arith(cmd) || is_logic(cmd);
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Winner selection between the EXE-stage port (0) and the auxiliary port (1),
// with a starvation counter that forces port 1 to win after STARVE_LIMIT
// consecutive lost arbitration cycles.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ARB_NORMAL | port 0 has priority; port 1 wins only when port 0 idle
//   ARB_FAVOR1 | port 1 starved; it wins whenever it is valid
module alu_arb_pick
  import alu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_can_accept,
  input  logic i_p0_valid,
  input  logic i_p1_valid,
  output logic o_win_valid,
  output logic o_win_sel
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sel;
  logic             w_p1_lost;
  logic             w_p1_hs;

  // Port 1 wins when it is alone or when it is being favoured
  always_comb begin
    w_sel     = i_p1_valid && (!i_p0_valid || (r_state == ARB_FAVOR1));
    w_p1_lost = i_can_accept && i_p1_valid && !w_sel;
    w_p1_hs   = i_can_accept && i_p1_valid && w_sel;
  end

  assign o_win_valid = i_p0_valid || i_p1_valid;
  assign o_win_sel   = w_sel;

  // Starvation counter and NORMAL/FAVOR1 state; both hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_NORMAL;
      r_cnt   <= '0;
    end else if (w_p1_hs) begin
      r_state <= ARB_NORMAL;
      r_cnt   <= '0;
    end else if (w_p1_lost) begin
      if (r_cnt != LIMIT) r_cnt <= r_cnt + 1'b1;
      if (r_cnt >= LIMIT_M1) r_state <= ARB_FAVOR1;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters: operand mux towards
// the ALU, a single-entry result register behind valid/ready, and the
// architectural NZCV status register that feeds the ALU carry-in.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TAG_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic [31:0]      p0_a,
  input  logic [31:0]      p0_b,
  input  logic [3:0]       p0_cmd,
  input  logic             p0_s,
  input  logic [TAG_W-1:0] p0_tag,
  input  logic             p1_valid,
  output logic             p1_ready,
  input  logic [31:0]      p1_a,
  input  logic [31:0]      p1_b,
  input  logic [3:0]       p1_cmd,
  input  logic             p1_s,
  input  logic [TAG_W-1:0] p1_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_cmd,
  output logic             alu_cin,
  input  logic [31:0]      alu_w,
  input  logic [3:0]       alu_sr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_w,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag,
  output logic [3:0]       sr
);

  logic             w_can_accept;
  logic             w_win_valid;
  logic             w_win_sel;
  logic             w_hs;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic [3:0]       w_cmd;
  logic             w_s;
  logic [TAG_W-1:0] w_tag;

  logic             r_res_valid;
  logic [31:0]      r_res_w;
  logic             r_res_src;
  logic [TAG_W-1:0] r_res_tag;
  logic [3:0]       r_sr;

  assign w_can_accept = !r_res_valid || res_ready;

  alu_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_can_accept (w_can_accept),
    .i_p0_valid   (p0_valid),
    .i_p1_valid   (p1_valid),
    .o_win_valid  (w_win_valid),
    .o_win_sel    (w_win_sel)
  );

  // Route the winning request to the ALU; an idle ALU sees all-zero inputs
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cmd = '0;
    w_s   = 1'b0;
    w_tag = '0;
    if (w_win_valid) begin
      if (w_win_sel) begin
        w_a   = p1_a;
        w_b   = p1_b;
        w_cmd = p1_cmd;
        w_s   = p1_s;
        w_tag = p1_tag;
      end else begin
        w_a   = p0_a;
        w_b   = p0_b;
        w_cmd = p0_cmd;
        w_s   = p0_s;
        w_tag = p0_tag;
      end
    end
  end

  // Readies are forced low while reset is asserted so nothing is consumed
  assign p0_ready = rst_n && w_can_accept && p0_valid && !w_win_sel;
  assign p1_ready = rst_n && w_can_accept && p1_valid && w_win_sel;
  assign w_hs     = p0_ready || p1_ready;

  assign alu_a   = w_a;
  assign alu_b   = w_b;
  assign alu_cmd = w_cmd;
  assign alu_cin = r_sr[SR_C];

  // Result register: a push overwrites any result popped in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_w     <= '0;
      r_res_src   <= 1'b0;
      r_res_tag   <= '0;
    end else if (w_hs) begin
      r_res_valid <= 1'b1;
      r_res_w     <= is_supported(w_cmd) ? alu_w : '0;
      r_res_src   <= w_win_sel;
      r_res_tag   <= w_tag;
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  // Status register: logic ops keep C and V, unsupported ops leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (w_hs && w_s) begin
      if (is_arith(w_cmd)) begin
        r_sr <= alu_sr;
      end else if (is_logic(w_cmd)) begin
        r_sr <= {alu_sr[SR_N], alu_sr[SR_Z], r_sr[SR_C], r_sr[SR_V]};
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_w     = r_res_w;
  assign res_src   = r_res_src;
  assign res_tag   = r_res_tag;
  assign sr        = r_sr;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural ALU stub, reference model of the
// arbiter and status register, and a scoreboard of expected results.
module tb_alu_share_arb;

  localparam int LIM = 4;
  localparam logic [3:0] MOV = 4'b0001, MVN = 4'b1001, ADD = 4'b0010,
                         ADC = 4'b0011, SUB = 4'b0100, SBC = 4'b0101,
                         AND = 4'b0110, ORR = 4'b0111, EOR = 4'b1000;

  typedef struct {
    logic [31:0] w;
    logic        src;
    logic [3:0]  tag;
  } exp_t;

  logic        clk, rst_n;
  logic        p0_valid, p0_ready, p0_s, p1_valid, p1_ready, p1_s;
  logic [31:0] p0_a, p0_b, p1_a, p1_b;
  logic [3:0]  p0_cmd, p1_cmd, p0_tag, p1_tag;
  logic [31:0] alu_a, alu_b, alu_w, res_w;
  logic [3:0]  alu_cmd, alu_sr, res_tag, sr;
  logic        alu_cin, res_valid, res_ready, res_src;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic m_rv;
  logic [3:0] m_sr;
  int   m_cnt;
  logic m_fav;
  logic [31:0] w_hold;

  alu_share_arb #(.STARVE_LIMIT(LIM), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_a(p0_a), .p0_b(p0_b),
    .p0_cmd(p0_cmd), .p0_s(p0_s), .p0_tag(p0_tag),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_a(p1_a), .p1_b(p1_b),
    .p1_cmd(p1_cmd), .p1_s(p1_s), .p1_tag(p1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_cin(alu_cin),
    .alu_w(alu_w), .alu_sr(alu_sr),
    .res_valid(res_valid), .res_ready(res_ready), .res_w(res_w),
    .res_src(res_src), .res_tag(res_tag), .sr(sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {N,Z,C,V, result}; unsupported cmds give junk
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c, input logic cin);
    logic [32:0] t;
    logic [31:0] w;
    logic        cy, v;
    t = '0; cy = 1'b0; v = 1'b0;
    case (c)
      MOV: w = b;
      MVN: w = ~b;
      AND: w = a & b;
      ORR: w = a | b;
      EOR: w = a ^ b;
      ADD, ADC: begin
        t  = {1'b0, a} + {1'b0, b} + ((c == ADC) ? {32'd0, cin} : 33'd0);
        w  = t[31:0]; cy = t[32];
        v  = (a[31] == b[31]) && (w[31] != a[31]);
      end
      SUB, SBC: begin
        t  = {1'b0, a} + {1'b0, ~b} + ((c == SUB) ? 33'd1 : {32'd0, cin});
        w  = t[31:0]; cy = t[32];
        v  = (a[31] != b[31]) && (w[31] != a[31]);
      end
      default: return {4'hF, a + b + 32'h1234};
    endcase
    return {w[31], (w == 32'd0), cy, v, w};
  endfunction

  // Combinational ALU stub driven by the DUT's mux outputs
  always_comb begin
    logic [35:0] f;
    f      = alu_f(alu_a, alu_b, alu_cmd, alu_cin);
    alu_w  = f[31:0];
    alu_sr = f[35:32];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic set_p0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic s, input logic [3:0] t);
    p0_valid = v; p0_a = a; p0_b = b; p0_cmd = c; p0_s = s; p0_tag = t;
  endtask

  task automatic set_p1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic s, input logic [3:0] t);
    p1_valid = v; p1_a = a; p1_b = b; p1_cmd = c; p1_s = s; p1_tag = t;
  endtask

  task automatic model_reset();
    q.delete();
    m_rv = 1'b0; m_sr = 4'b0000; m_cnt = 0; m_fav = 1'b0;
  endtask

  // One clock cycle: check against the model, update scoreboard, advance
  task automatic cyc();
    logic can, any, ew, e0, e1, pop, sup;
    logic [31:0] ea, eb;
    logic [3:0]  ec, et;
    logic        es;
    logic [35:0] f;
    exp_t        e, n;
    #1;
    can = !m_rv || res_ready;
    any = p0_valid || p1_valid;
    ew  = p1_valid && (!p0_valid || m_fav);
    e0  = can && p0_valid && !ew;
    e1  = can && p1_valid && ew;
    ea = '0; eb = '0; ec = '0; es = 1'b0; et = '0;
    if (any) begin
      if (ew) begin ea = p1_a; eb = p1_b; ec = p1_cmd; es = p1_s; et = p1_tag; end
      else    begin ea = p0_a; eb = p0_b; ec = p0_cmd; es = p0_s; et = p0_tag; end
    end
    chk("p0_ready", 32'(p0_ready), 32'(e0));
    chk("p1_ready", 32'(p1_ready), 32'(e1));
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("alu_cmd", 32'(alu_cmd), 32'(ec));
    chk("alu_cin", 32'(alu_cin), 32'(m_sr[1]));
    chk("sr", 32'(sr), 32'(m_sr));
    chk("res_valid", 32'(res_valid), 32'(m_rv));
    if (m_rv) begin
      chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q[0];
        chk("res_w", res_w, e.w);
        chk("res_src", 32'(res_src), 32'(e.src));
        chk("res_tag", 32'(res_tag), 32'(e.tag));
      end
    end
    pop = m_rv && res_ready;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (e0 || e1) begin
      sup   = (ec >= 4'd1) && (ec <= 4'd9);
      f     = alu_f(ea, eb, ec, m_sr[1]);
      n.w   = sup ? f[31:0] : 32'd0;
      n.src = e1;
      n.tag = et;
      q.push_back(n);
      if (sup && es) begin
        if (ec >= 4'd2 && ec <= 4'd5) m_sr = f[35:32];
        else                          m_sr = {f[35], f[34], m_sr[1:0]};
      end
      m_rv = 1'b1;
    end else if (pop) begin
      m_rv = 1'b0;
    end
    if (e1) begin
      m_cnt = 0; m_fav = 1'b0;
    end else if (can && p1_valid) begin
      if (m_cnt < LIM) m_cnt++;
      if (m_cnt >= LIM) m_fav = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  tcmd [9];
    tcmd = '{MOV, MVN, ORR, EOR, SUB, SBC, ADC, ADD, 4'b0000};

    rst_n = 1'b0; res_ready = 1'b1;
    set_p0(1'b1, 32'd1, 32'd1, ADD, 1'b1, 4'd1);
    set_p1(1'b1, 32'd2, 32'd2, ADD, 1'b1, 4'd2);
    model_reset();
    @(negedge clk); @(negedge clk);
    // readies stay low while held in reset, even with requests pending
    chk("rst_p0_ready", 32'(p0_ready), 32'd0);
    chk("rst_p1_ready", 32'(p1_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_sr", 32'(sr), 32'd0);
    set_p0(1'b0, 0, 0, 4'd0, 1'b0, 4'd0);
    set_p1(1'b0, 0, 0, 4'd0, 1'b0, 4'd0);
    rst_n = 1'b1;
    cyc();

    // Overflow flags
    set_p0(1'b1, 32'h7FFF_FFFF, 32'h1, ADD, 1'b1, 4'd2);
    cyc();
    set_p0(1'b0, 0, 0, 4'd0, 1'b0, 4'd0);
    chk("flags_res_w", res_w, 32'h8000_0000);
    chk("flags_sr", 32'(sr), 32'b1001);
    cyc();

    // Carry chain ADD -> ADC with no bubble
    set_p0(1'b1, 32'hFFFF_FFFF, 32'h1, ADD, 1'b1, 4'd3);
    cyc();
    chk("chain_sr_add", 32'(sr), 32'b0110);
    set_p0(1'b1, 32'h0, 32'h0, ADC, 1'b0, 4'd4);
    cyc();
    chk("chain_res_w", res_w, 32'h1);
    chk("chain_sr_adc", 32'(sr), 32'b0110);
    set_p0(1'b0, 0, 0, 4'd0, 1'b0, 4'd0);
    cyc();

    // Logic ops keep C,V; unsupported op gives zero and leaves sr
    set_p0(1'b1, 32'h8000_0000, 32'h1, SUB, 1'b1, 4'd5);
    cyc();
    chk("logic_sr_pre", 32'(sr), 32'b0011);
    set_p0(1'b1, 32'hF0, 32'h0F, AND, 1'b1, 4'd6);
    cyc();
    chk("logic_and_w", res_w, 32'h0);
    chk("logic_and_sr", 32'(sr), 32'b0111);
    set_p0(1'b1, 32'd5, 32'd6, 4'b1111, 1'b1, 4'd7);
    cyc();
    chk("unsup_w", res_w, 32'h0);
    chk("unsup_sr", 32'(sr), 32'b0111);
    set_p0(1'b0, 0, 0, 4'd0, 1'b0, 4'd0);
    cyc();

    // Assorted ops from port 1 alone
    for (int i = 0; i < 9; i++) begin
      set_p1(1'b1, $urandom, (i == 4) ? 32'h0 : $urandom, tcmd[i], 1'(i % 2), 4'(i));
      cyc();
    end
    set_p1(1'b0, 0, 0, 4'd0, 1'b0, 4'd0);
    cyc();

    // Asynchronous reset with a result held under backpressure
    res_ready = 1'b0;
    set_p0(1'b1, 32'd2, 32'd2, ADD, 1'b1, 4'd8);
    cyc();
    chk("pre_rst_valid", 32'(res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_res_w", res_w, 32'd0);
    chk("arst_res_src", 32'(res_src), 32'd0);
    chk("arst_res_tag", 32'(res_tag), 32'd0);
    chk("arst_sr", 32'(sr), 32'd0);
    chk("arst_p0_ready", 32'(p0_ready), 32'd0);
    chk("arst_p1_ready", 32'(p1_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; res_ready = 1'b1;
    model_reset();
    set_p0(1'b1, 32'd2, 32'd3, ADD, 1'b0, 4'd5);
    cyc();
    chk("post_rst_w", res_w, 32'd5);
    set_p0(1'b0, 0, 0, 4'd0, 1'b0, 4'd0);
    cyc();

    // Starvation: both valid, port 1 wins every fifth grant
    set_p0(1'b1, 32'd10, 32'd20, ADD, 1'b0, 4'd1);
    set_p1(1'b1, 32'd50, 32'd7, SUB, 1'b0, 4'd9);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("starve_tag", 32'(res_tag), (i % 5 == 4) ? 32'd9 : 32'd1);
    end

    // Backpressure freezes grants, result and starvation count
    cyc(); cyc();
    res_ready = 1'b0;
    cyc();
    w_hold = res_w;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_p0_ready", 32'(p0_ready), 32'd0);
      chk("bp_p1_ready", 32'(p1_ready), 32'd0);
      chk("bp_res_w", res_w, w_hold);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_p0", 32'(p0_ready), 32'd1);
    cyc();
    cyc();
    chk("bp_then_p1_pending", 32'(res_tag), 32'd1);
    cyc();
    chk("bp_then_p1", 32'(res_tag), 32'd9);

    set_p0(1'b0, 0, 0, 4'd0, 1'b0, 4'd0);
    set_p1(1'b0, 0, 0, 4'd0, 1'b0, 4'd0);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
